// File: rtl/nibble_sub_pkg.sv
// nibble_sub_pkg: shared nibble width and FSM state encoding for the serial subtractor
package nibble_sub_pkg;
  localparam int NIBBLE_W = 4;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/nibble_sub.sv
// nibble_sub: combinational 4-bit subtract with borrow, mirror of the 4-bit ripple adder
module nibble_sub
  import nibble_sub_pkg::*;
(
  input  logic                bin,
  input  logic [NIBBLE_W-1:0] A,
  input  logic [NIBBLE_W-1:0] B,
  output logic [NIBBLE_W-1:0] D,
  output logic                Bout
);
  assign {Bout, D} = {1'b0, A} - {1'b0, B} - {{NIBBLE_W{1'b0}}, bin};
endmodule

// File: rtl/nibble_serial_subtractor.sv
// nibble_serial_subtractor: A - B - BIN one nibble per clock, LSB first, valid/ready on both sides
module nibble_serial_subtractor
  import nibble_sub_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero,
  output logic             ovf
);
  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int CW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;
  if (WIDTH % NIBBLE_W != 0 || WIDTH < NIBBLE_W) begin : g_width_check
    $error("WIDTH must be a multiple of 4 and at least 4");
  end
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] a_q, b_q, res, res_nx;
  logic [NIBBLE_W-1:0] nd;
  logic br, nb_out, last, accept, zero_nx, ovf_nx;
  nibble_sub u_sub (
    .bin (br),
    .A   (a_q[cnt*NIBBLE_W +: NIBBLE_W]),
    .B   (b_q[cnt*NIBBLE_W +: NIBBLE_W]),
    .D   (nd),
    .Bout(nb_out)
  );
  assign last = cnt == CW'(NIBBLES - 1);
  assign accept = in_valid && in_ready;
  assign diff = res;
  assign bout = br;
  // result with the current nibble merged in, and the flags it would produce
  always_comb begin
    res_nx = res;
    res_nx[cnt*NIBBLE_W +: NIBBLE_W] = nd;
    zero_nx = res_nx == '0;
    ovf_nx = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (res_nx[WIDTH-1] != a_q[WIDTH-1]);
  end
  // next state and handshake outputs
  always_comb begin
    in_ready = state == IDLE;
    out_valid = state == DONE;
    state_nx = (state == IDLE && in_valid) ? RUN :
               (state == RUN && last) ? DONE :
               (state == DONE && out_ready) ? IDLE : state;
  end
  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  // operand capture, per-nibble result/borrow update, flag capture on the last nibble
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      a_q <= '0;
      b_q <= '0;
      res <= '0;
      br <= 1'b0;
      zero <= 1'b0;
      ovf <= 1'b0;
    end else if (accept) begin
      a_q <= a;
      b_q <= b;
      br <= bin;
      cnt <= '0;
    end else if (state == RUN) begin
      res <= res_nx;
      br <= nb_out;
      cnt <= cnt + 1'b1;
      if (last) begin
        zero <= zero_nx;
        ovf <= ovf_nx;
      end
    end
  end
endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// tb_nibble_serial_subtractor: directed vectors with hand-computed results for the 16-bit subtractor
module tb_nibble_serial_subtractor;
  logic clk, rst_n, in_valid, in_ready, bin, out_valid, out_ready, bout, zero, ovf;
  logic [15:0] a, b, diff;
  int checks = 0;
  int errors = 0;
  nibble_serial_subtractor #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bout(bout), .zero(zero), .ovf(ovf)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic accept_op(input logic [15:0] ta, input logic [15:0] tb_, input logic tbin);
    chk("in_ready_before_accept", in_ready, 1);
    a = ta;
    b = tb_;
    bin = tbin;
    in_valid = 1;
    step();
    in_valid = 0;
    a = ~ta;
    b = 16'h5555;
    bin = ~tbin;
  endtask
  task automatic wait_done(input string tag);
    int n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_latency"}, n, 4);
  endtask
  task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_, input logic tbin,
                        input logic [15:0] ed, input logic eb, input logic ez, input logic eo);
    accept_op(ta, tb_, tbin);
    wait_done(tag);
    chk({tag, "_diff"}, diff, ed);
    chk({tag, "_bout"}, bout, eb);
    chk({tag, "_zero"}, zero, ez);
    chk({tag, "_ovf"}, ovf, eo);
    out_ready = 1;
    step();
    out_ready = 0;
    chk({tag, "_idle_out_valid"}, out_valid, 0);
    chk({tag, "_idle_in_ready"}, in_ready, 1);
  endtask
  initial begin
    rst_n = 0;
    in_valid = 0;
    out_ready = 0;
    a = 0;
    b = 0;
    bin = 0;
    step();
    step();
    rst_n = 1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_diff", diff, 0);
    chk("rst_flags", {bout, zero, ovf}, 0);
    run_op("basic", 16'h1234, 16'h0234, 0, 16'h1000, 0, 0, 0);
    run_op("wrap1", 16'h0000, 16'h0001, 0, 16'hFFFF, 1, 0, 0);
    run_op("wrap_bin", 16'h0000, 16'h0000, 1, 16'hFFFF, 1, 0, 0);
    run_op("chain", 16'h1000, 16'h0001, 0, 16'h0FFF, 0, 0, 0);
    run_op("zero", 16'h5A5A, 16'h5A59, 1, 16'h0000, 0, 1, 0);
    run_op("ovf", 16'h8000, 16'h0001, 0, 16'h7FFF, 0, 0, 1);
    accept_op(16'h0003, 16'h0005, 0);
    wait_done("bp");
    for (int i = 0; i < 3; i++) begin
      in_valid = 1;
      a = 16'h7777;
      b = 16'h1111;
      step();
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_diff", diff, 16'hFFFE);
      chk("bp_flags", {bout, zero, ovf}, 3'b100);
    end
    in_valid = 0;
    out_ready = 1;
    step();
    out_ready = 0;
    chk("bp_release_in_ready", in_ready, 1);
    chk("bp_release_out_valid", out_valid, 0);
    step();
    chk("bp_no_spurious_start", in_ready, 1);
    accept_op(16'hFFFF, 16'h0001, 0);
    step();
    step();
    rst_n = 0;
    step();
    rst_n = 1;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_diff", diff, 0);
    chk("midrst_bout", bout, 0);
    run_op("after_rst", 16'h0010, 16'h0001, 0, 16'h000F, 0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
